// File: rtl/wb_pkg.sv
//------------------------------------------------------------------------------
// Module      : wb_pkg
// Description : Shared constants for the writeback stage (load types, states).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package wb_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
//------------------------------------------------------------------------------
// Module      : load_extend
// Description : Selects the addressed byte/half of a load word and extends it.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_extend
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[{addr_lo, 3'b000} +: 8];
        // Halfword alignment ignores the low address bit.
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      value = {{(XLEN-8){w_byte[7]}}, w_byte};
            LBU:     value = {{(XLEN-8){1'b0}}, w_byte};
            LH:      value = {{(XLEN-16){w_half[15]}}, w_half};
            LHU:     value = {{(XLEN-16){1'b0}}, w_half};
            default: value = rdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
//------------------------------------------------------------------------------
// Module      : writeback_unit
// Description : Final pipeline stage; owns the register-file write port,
//               tracks outstanding loads and bypasses writes to decode reads.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_unit
    import wb_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             ex_rd_we,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic [2:0]       ex_funct3,
    input  logic [1:0]       ex_addr_lo,
    input  logic [XLEN-1:0]  ex_result,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             stall,
    output logic             rf_we,
    output logic [REG_W-1:0] rf_dst_num,
    output logic [XLEN-1:0]  rf_dst_value,
    input  logic [REG_W-1:0] rd1_num,
    input  logic [REG_W-1:0] rd2_num,
    input  logic [XLEN-1:0]  rd1_raw,
    input  logic [XLEN-1:0]  rd2_raw,
    output logic [XLEN-1:0]  rd1_value,
    output logic [XLEN-1:0]  rd2_value
);

    logic [0:0]       r_state;
    logic [REG_W-1:0] r_ld_rd;
    logic             r_ld_we;
    logic [2:0]       r_ld_funct3;
    logic [1:0]       r_ld_addr_lo;
    logic [XLEN-1:0]  w_load_value;
    logic             w_load_writes;
    logic             w_alu_writes;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .funct3  (r_ld_funct3),
        .addr_lo (r_ld_addr_lo),
        .rdata   (mem_rdata),
        .value   (w_load_value)
    );

    assign w_alu_writes  = ex_valid && !ex_is_load && ex_rd_we && (ex_rd != '0);
    assign w_load_writes = r_ld_we && (r_ld_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_ld_rd      <= '0;
            r_ld_we      <= 1'b0;
            r_ld_funct3  <= '0;
            r_ld_addr_lo <= '0;
            rf_we        <= 1'b0;
            rf_dst_num   <= '0;
            rf_dst_value <= '0;
        end else begin
            rf_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (ex_valid && ex_is_load) begin
                        r_ld_rd      <= ex_rd;
                        r_ld_we      <= ex_rd_we;
                        r_ld_funct3  <= ex_funct3;
                        r_ld_addr_lo <= ex_addr_lo;
                        r_state      <= LOAD_WAIT;
                    end else if (w_alu_writes) begin
                        rf_we        <= 1'b1;
                        rf_dst_num   <= ex_rd;
                        rf_dst_value <= ex_result;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        r_state <= IDLE;
                        if (w_load_writes) begin
                            rf_we        <= 1'b1;
                            rf_dst_num   <= r_ld_rd;
                            rf_dst_value <= w_load_value;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall = (r_state == LOAD_WAIT);

    // x0 is never forwarded so it always reads as the raw (zero) value.
    assign rd1_value = (rf_we && (rd1_num == rf_dst_num) && (rd1_num != '0)) ? rf_dst_value : rd1_raw;
    assign rd2_value = (rf_we && (rd2_num == rf_dst_num) && (rd2_num != '0)) ? rf_dst_value : rd2_raw;

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_writeback_unit
// Description : Directed self-checking bench for writeback_unit.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_writeback_unit;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_rd_we, ex_is_load, mem_rvalid;
    logic [4:0]  ex_rd, rd1_num, rd2_num, rf_dst_num;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic [31:0] ex_result, mem_rdata, rd1_raw, rd2_raw;
    logic [31:0] rf_dst_value, rd1_value, rd2_value;
    logic        stall, rf_we;

    int total = 0;
    int bad   = 0;

    writeback_unit #(.XLEN(32), .REG_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .ex_rd_we     (ex_rd_we),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_funct3    (ex_funct3),
        .ex_addr_lo   (ex_addr_lo),
        .ex_result    (ex_result),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_dst_num   (rf_dst_num),
        .rf_dst_value (rf_dst_value),
        .rd1_num      (rd1_num),
        .rd2_num      (rd2_num),
        .rd1_raw      (rd1_raw),
        .rd2_raw      (rd2_raw),
        .rd1_value    (rd1_value),
        .rd2_value    (rd2_value)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] res);
        ex_valid   = 1'b1;
        ex_is_load = 1'b0;
        ex_rd_we   = 1'b1;
        ex_rd      = rd;
        ex_result  = res;
        ex_funct3  = LW;
        ex_addr_lo = 2'd0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ex_valid = 0; ex_rd_we = 0; ex_is_load = 0; mem_rvalid = 0;
        ex_rd = 0; ex_funct3 = 0; ex_addr_lo = 0; ex_result = 0; mem_rdata = 0;
        rd1_num = 0; rd2_num = 0; rd1_raw = 0; rd2_raw = 0;
        #12;
        total++;
        if (stall !== 1'b0 || rf_we !== 1'b0 || rf_dst_num !== 5'd0 || rf_dst_value !== 32'd0) begin
            bad++;
            $display("FAIL reset: stall=%b rf_we=%b num=%0d val=%h, want 0 0 0 0", stall, rf_we, rf_dst_num, rf_dst_value);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_alu_bypass;
        set_alu(5'd5, 32'h0000_1234);
        tick;
        ex_valid = 1'b0;
        rd1_num = 5'd5; rd1_raw = 32'h0;
        rd2_num = 5'd6; rd2_raw = 32'hCAFE_0006;
        #1;
        total++;
        if (rf_we !== 1'b1 || rf_dst_num !== 5'd5 || rf_dst_value !== 32'h0000_1234) begin
            bad++;
            $display("FAIL alu_write: we=%b num=%0d val=%h, want 1 5 00001234", rf_we, rf_dst_num, rf_dst_value);
        end
        total++;
        if (rd1_value !== 32'h0000_1234) begin
            bad++;
            $display("FAIL bypass_hit: rd1_value=%h, want 00001234", rd1_value);
        end
        total++;
        if (rd2_value !== 32'hCAFE_0006) begin
            bad++;
            $display("FAIL bypass_miss: rd2_value=%h, want cafe0006", rd2_value);
        end
        tick;
        total++;
        if (rf_we !== 1'b0 || rd1_value !== 32'h0) begin
            bad++;
            $display("FAIL alu_pulse: we=%b rd1_value=%h, want 0 00000000", rf_we, rd1_value);
        end
        rd1_num = 0; rd2_num = 0; rd2_raw = 0;
    endtask

    // Issues a load, holds a stray ALU instruction on ex_* while stalled,
    // answers after `waits` idle cycles and checks the resulting write.
    task automatic run_load(input string name, input logic [2:0] f3, input logic [1:0] alo,
                            input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                            input logic exp_we, input logic [31:0] exp_val);
        int stall_cycles;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd = rd;
        ex_funct3 = f3; ex_addr_lo = alo; ex_result = 32'hDEAD_BEEF;
        mem_rvalid = 1'b0;
        tick;
        set_alu(5'd20, 32'h5555_5555);
        stall_cycles = 0;
        for (int i = 0; i <= waits; i++) begin
            mem_rvalid = (i == waits);
            mem_rdata  = (i == waits) ? rdata : 32'hA5A5_A5A5;
            if (stall === 1'b1 && rf_we === 1'b0) stall_cycles++;
            tick;
        end
        ex_valid = 1'b0; mem_rvalid = 1'b0;
        total++;
        if (stall_cycles != waits + 1) begin
            bad++;
            $display("FAIL %s_stall: stalled-no-write cycles=%0d, want %0d", name, stall_cycles, waits + 1);
        end
        total++;
        if (stall !== 1'b0 || rf_we !== exp_we || (exp_we && (rf_dst_num !== rd || rf_dst_value !== exp_val))) begin
            bad++;
            $display("FAIL %s_write: stall=%b we=%b num=%0d val=%h, want 0 %b %0d %h",
                     name, stall, rf_we, rf_dst_num, rf_dst_value, exp_we, rd, exp_val);
        end
        tick;
        total++;
        if (rf_we !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL %s_after: we=%b stall=%b, want 0 0", name, rf_we, stall);
        end
    endtask

    task automatic test_loads;
        run_load("lb",    LB,  2'd2, 5'd7,  3, 32'h1280_FF00, 1'b1, 32'hFFFF_FF80);
        run_load("lbu",   LBU, 2'd2, 5'd8,  3, 32'h1280_FF00, 1'b1, 32'h0000_0080);
        run_load("lb1",   LB,  2'd1, 5'd9,  0, 32'h1280_FF00, 1'b1, 32'hFFFF_FFFF);
        run_load("lh",    LH,  2'd2, 5'd10, 1, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001);
        run_load("lhu",   LHU, 2'd3, 5'd11, 2, 32'h8001_7FFF, 1'b1, 32'h0000_8001);
        run_load("lh_lo", LH,  2'd0, 5'd12, 0, 32'h8001_7FFF, 1'b1, 32'h0000_7FFF);
        run_load("lw",    LW,  2'd0, 5'd13, 1, 32'h8001_7FFF, 1'b1, 32'h8001_7FFF);
    endtask

    task automatic test_x0;
        set_alu(5'd0, 32'h1111_1111);
        tick;
        ex_valid = 1'b0;
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL alu_x0: we=%b, want 0", rf_we);
        end
        run_load("load_x0", LW, 2'd0, 5'd0, 2, 32'h2222_2222, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_load;
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd_we = 1'b1; ex_rd = 5'd14;
        ex_funct3 = LW; ex_addr_lo = 2'd0;
        tick;
        ex_valid = 1'b0;
        tick;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: stall=%b, want 1", stall);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0 || rf_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: stall=%b we=%b, want 0 0", stall, rf_we);
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333;
        #2 rst_n = 1'b1;
        tick;
        mem_rvalid = 1'b0;
        total++;
        if (rf_we !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL rst_late_resp: we=%b stall=%b, want 0 0", rf_we, stall);
        end
        set_alu(5'd9, 32'h0000_ABCD);
        tick;
        ex_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_dst_num !== 5'd9 || rf_dst_value !== 32'h0000_ABCD) begin
            bad++;
            $display("FAIL rst_next_alu: we=%b num=%0d val=%h, want 1 9 0000abcd", rf_we, rf_dst_num, rf_dst_value);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h0000_0011; vals[1] = 32'h0000_0022; vals[2] = 32'h0000_0033;
        mem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            set_alu(5'(i + 1), vals[i]);
            mem_rvalid = (i != 1);
            tick;
            rd2_num = 5'(i + 1); rd2_raw = 32'h0;
            #1;
            total++;
            if (rf_we !== 1'b1 || rf_dst_num !== 5'(i + 1) || rf_dst_value !== vals[i] || stall !== 1'b0 || rd2_value !== vals[i]) begin
                bad++;
                $display("FAIL b2b_%0d: we=%b num=%0d val=%h stall=%b rd2=%h, want 1 %0d %h 0 %h",
                         i, rf_we, rf_dst_num, rf_dst_value, stall, rd2_value, i + 1, vals[i], vals[i]);
            end
        end
        ex_valid = 1'b0; mem_rvalid = 1'b1;
        tick;
        total++;
        if (rf_we !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: we=%b stall=%b, want 0 0", rf_we, stall);
        end
        mem_rvalid = 1'b0; rd2_num = 0;
    endtask

    initial begin
        test_reset;
        test_alu_bypass;
        test_loads;
        test_x0;
        test_reset_mid_load;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
